// File: rtl/prog_harness.sv
// Program-loading test harness: holds a small program image served on the CPU
// fetch port, runs it until the halt address or a cycle budget, then checks v0.
module prog_harness #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 16,
  parameter logic [WIDTH-1:0] BASE_ADDR = 32'hBFC00000,
  parameter logic [WIDTH-1:0] HALT_ADDR = '0,
  parameter int unsigned      TIMEOUT   = 1024,
  parameter logic [WIDTH-1:0] NOP_WORD  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] expected,
  input  logic [WIDTH-1:0] instr_address,
  output logic [WIDTH-1:0] instr_readdata,
  input  logic [WIDTH-1:0] register_v0,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             timed_out,
  output logic             overflow,
  output logic [15:0]      cycles,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LW-1:0]    r_len;
  logic             r_overflow;
  logic             r_pass;
  logic             r_timed_out;
  logic [15:0]      r_cycles;
  logic [WIDTH-1:0] r_result;

  logic [WIDTH-1:0] w_off;
  logic [WIDTH-1:0] w_idx;
  logic             w_hit;
  logic             w_halt;
  logic             w_tmo;
  logic             w_full;
  logic             w_load;

  // Fetch path: only words inside the loaded part of the window are served.
  assign w_off  = instr_address - BASE_ADDR;
  assign w_idx  = w_off >> 2;
  assign w_hit  = (instr_address >= BASE_ADDR) && (w_off[1:0] == 2'b00) &&
                  (w_idx < WIDTH'(r_len));
  assign instr_readdata = w_hit ? r_mem[w_idx[AW-1:0]] : NOP_WORD;

  assign w_halt = (instr_address == HALT_ADDR);
  assign w_tmo  = (r_cycles == 16'(TIMEOUT - 1));
  assign w_full = (r_len == LW'(DEPTH));
  assign w_load = (r_state == S_IDLE) && load_en && !clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start && !load_en) w_next = S_RUN;
        S_RUN:   if (w_halt) w_next = S_CHECK;
                 else if (w_tmo) w_next = S_DONE;
        S_CHECK: w_next = S_DONE;
        S_DONE:  if (start) w_next = S_RUN;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    running = (r_state == S_RUN) || (r_state == S_CHECK);
    done    = (r_state == S_DONE);
  end

  // Program image is deliberately left out of reset; length gates every read.
  always_ff @(posedge clk) begin
    if (w_load && !w_full) r_mem[r_len[AW-1:0]] <= load_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len       <= '0;
      r_overflow  <= 1'b0;
      r_pass      <= 1'b0;
      r_timed_out <= 1'b0;
      r_cycles    <= '0;
      r_result    <= '0;
    end else if (clear) begin
      r_len       <= '0;
      r_overflow  <= 1'b0;
      r_pass      <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_en) begin
            if (w_full) r_overflow <= 1'b1;
            else        r_len      <= r_len + LW'(1);
          end else if (start) begin
            r_cycles <= '0;
          end
        end
        S_RUN: begin
          // Count only while staying in RUN, so cycles freezes at the exit cycle.
          if (!w_halt && w_tmo) begin
            r_timed_out <= 1'b1;
            r_pass      <= 1'b0;
          end else if (!w_halt && (r_cycles != '1)) begin
            r_cycles <= r_cycles + 16'd1;
          end
        end
        S_CHECK: begin
          r_result    <= register_v0;
          r_pass      <= (register_v0 == expected);
          r_timed_out <= 1'b0;
        end
        S_DONE: begin
          if (start) begin
            r_cycles    <= '0;
            r_pass      <= 1'b0;
            r_timed_out <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign pass      = r_pass;
  assign timed_out = r_timed_out;
  assign overflow  = r_overflow;
  assign cycles    = r_cycles;
  assign result    = r_result;

endmodule

// File: tb/tb_prog_harness.sv
// Scoreboard bench for prog_harness: a long-budget instance and a TIMEOUT=8
// instance share one stimulus stream.
module tb_prog_harness;

  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam logic [31:0] HALT = 32'h0;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en, clear, start;
  logic [31:0] load_data, expected, instr_address, register_v0;

  logic [31:0] a_rd, b_rd, a_result, b_result;
  logic        a_running, a_done, a_pass, a_to, a_ovf;
  logic        b_running, b_done, b_pass, b_to, b_ovf;
  logic [15:0] a_cycles, b_cycles;

  prog_harness #(.WIDTH(32), .DEPTH(4), .BASE_ADDR(BASE), .HALT_ADDR(HALT),
                 .TIMEOUT(1024), .NOP_WORD(NOP)) u_dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_data(load_data),
    .clear(clear), .start(start), .expected(expected),
    .instr_address(instr_address), .instr_readdata(a_rd),
    .register_v0(register_v0), .running(a_running), .done(a_done),
    .pass(a_pass), .timed_out(a_to), .overflow(a_ovf),
    .cycles(a_cycles), .result(a_result));

  prog_harness #(.WIDTH(32), .DEPTH(4), .BASE_ADDR(BASE), .HALT_ADDR(HALT),
                 .TIMEOUT(8), .NOP_WORD(NOP)) u_to (
    .clk(clk), .reset(reset), .load_en(load_en), .load_data(load_data),
    .clear(clear), .start(start), .expected(expected),
    .instr_address(instr_address), .instr_readdata(b_rd),
    .register_v0(register_v0), .running(b_running), .done(b_done),
    .pass(b_pass), .timed_out(b_to), .overflow(b_ovf),
    .cycles(b_cycles), .result(b_result));

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk(e.tag, got, e.exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] d);
    load_en   = 1'b1;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp);
    push("fetch", exp);
    instr_address = addr;
    #1;
    pop_chk(a_rd);
  endtask

  // Starts a run, drives the halt address while cycles == halt_at (never if
  // negative), and drains the scoreboard as each instance reaches DONE.
  task automatic do_run(input int halt_at, input logic [31:0] v0, input logic [31:0] ex);
    bit seen_a = 1'b0;
    bit seen_b = 1'b0;
    register_v0   = v0;
    expected      = ex;
    instr_address = BASE;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 60 && !(seen_a && seen_b); c++) begin
      if (c == halt_at) instr_address = HALT;
      tick();
      if (b_done && !seen_b) begin
        seen_b = 1'b1;
        pop_chk({31'd0, b_pass});
        pop_chk({31'd0, b_to});
        pop_chk({16'd0, b_cycles});
      end
      if (a_done && !seen_a) begin
        seen_a = 1'b1;
        pop_chk({31'd0, a_pass});
        pop_chk({31'd0, a_to});
        pop_chk(a_result);
        pop_chk({16'd0, a_cycles});
      end
    end
    if (!(seen_a && seen_b)) begin
      chk("run_never_done", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic push_b(input bit p, input bit t, input int cyc);
    push("to_pass", {31'd0, p});
    push("to_timed_out", {31'd0, t});
    push("to_cycles", cyc);
  endtask

  task automatic push_a(input bit p, input bit t, input logic [31:0] res, input int cyc);
    push("pass", {31'd0, p});
    push("timed_out", {31'd0, t});
    push("result", res);
    push("cycles", cyc);
  endtask

  initial begin
    reset = 1'b0; load_en = 1'b0; clear = 1'b0; start = 1'b0;
    load_data = '0; expected = '0; instr_address = BASE; register_v0 = '0;
    repeat (2) @(posedge clk);
    #1;
    push("rst_running", 0); pop_chk({31'd0, a_running});
    push("rst_done", 0);    pop_chk({31'd0, a_done});
    push("rst_pass", 0);    pop_chk({31'd0, a_pass});
    push("rst_to", 0);      pop_chk({31'd0, a_to});
    push("rst_ovf", 0);     pop_chk({31'd0, a_ovf});
    push("rst_cycles", 0);  pop_chk({16'd0, a_cycles});
    push("rst_result", 0);  pop_chk(a_result);
    reset = 1'b1;
    tick();

    load(32'h11111111); load(32'h22222222); load(32'h33333333);
    fetch(BASE,      32'h11111111);
    fetch(BASE + 4,  32'h22222222);
    fetch(BASE + 8,  32'h33333333);
    fetch(BASE + 12, NOP);
    fetch(BASE + 2,  NOP);
    fetch(BASE - 4,  NOP);

    push_b(1'b0, 1'b1, 7);
    push_a(1'b1, 1'b0, 32'd44, 10);
    do_run(10, 32'd44, 32'd44);

    push_b(1'b0, 1'b1, 7);
    push_a(1'b0, 1'b0, 32'd44, 10);
    do_run(10, 32'd44, 32'd45);

    push_b(1'b1, 1'b0, 7);
    push_a(1'b1, 1'b0, 32'd9, 7);
    do_run(7, 32'd9, 32'd9);
    push("to_result_same_cycle", 32'd9); pop_chk(b_result);

    clear = 1'b1; tick(); clear = 1'b0;
    push("clear_done", 0); pop_chk({31'd0, a_done});
    for (int i = 0; i < 5; i++) load(32'hA0000000 + i);
    push("overflow_set", 1); pop_chk({31'd0, a_ovf});
    for (int i = 0; i < 4; i++) fetch(BASE + 4 * i, 32'hA0000000 + i);
    fetch(BASE + 16, NOP);
    clear = 1'b1; tick(); clear = 1'b0;
    push("overflow_clr", 0); pop_chk({31'd0, a_ovf});
    for (int i = 0; i < 4; i++) fetch(BASE + 4 * i, NOP);

    load(32'h55555555); load(32'h66666666);
    instr_address = BASE;
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    push("mid_running", 1); pop_chk({31'd0, a_running});
    #2 reset = 1'b0;
    #1;
    push("async_running", 0); pop_chk({31'd0, a_running});
    push("async_done", 0);    pop_chk({31'd0, a_done});
    repeat (3) tick();
    push("held_done", 0);     pop_chk({31'd0, a_done});
    reset = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    push("rerun_running", 1); pop_chk({31'd0, a_running});
    fetch(BASE,     NOP);
    fetch(BASE + 4, NOP);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=stalled expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/prog_harness.md
PROG_HARNESS -- requirements
Module: prog_harness

Interface
REQ-001 Parameter WIDTH, default 32, data and address width.
REQ-002 Parameter DEPTH, default 16, program words held.
REQ-003 Parameter BASE_ADDR, default 32'hBFC00000, byte address of word 0.
REQ-004 Parameter HALT_ADDR, default 0, fetch address that signals program end.
REQ-005 Parameter TIMEOUT, default 1024, maximum RUN cycles.
REQ-006 Parameter NOP_WORD, default 0, word returned outside the loaded program.
REQ-007 clk  in  1  single clock; all state changes on rising edge.
REQ-008 reset  in  1  asynchronous, active-low (0 = reset).
REQ-009 load_en  in  1  write load_data at the load pointer.
REQ-010 load_data  in  WIDTH  program word.
REQ-011 clear  in  1  return to IDLE and empty the program.
REQ-012 start  in  1  begin a run.
REQ-013 expected  in  WIDTH  value register_v0 must hold at halt.
REQ-014 instr_address  in  WIDTH  CPU fetch address.
REQ-015 instr_readdata  out  WIDTH  fetched word.
REQ-016 register_v0  in  WIDTH  CPU result register.
REQ-017 running  out  1  high in RUN or CHECK.
REQ-018 done  out  1  high in DONE.
REQ-019 pass  out  1  valid while done.
REQ-020 timed_out  out  1  valid while done.
REQ-021 overflow  out  1  load attempted with program full; sticky until clear or reset.
REQ-022 cycles  out  16  RUN cycle count.
REQ-023 result  out  WIDTH  captured register_v0.

Function
REQ-024 States SHALL be IDLE, RUN, CHECK, DONE.
REQ-025 Fetch path SHALL be combinational: idx = (instr_address - BASE_ADDR) >> 2; return mem[idx] only if address is in window, word-aligned, and idx < length; else NOP_WORD.
REQ-026 IDLE: load_en writes mem[length], length increments; at length == DEPTH the write is dropped and overflow sets.
REQ-027 IDLE: start with load_en low -> RUN, cycles cleared to 0; load_en and start together: load performed, start ignored.
REQ-028 load_en SHALL be ignored outside IDLE.
REQ-029 RUN: cycles increments each cycle, saturating at 16'hFFFF.
REQ-030 RUN: instr_address == HALT_ADDR -> CHECK next edge.
REQ-031 RUN: cycles == TIMEOUT-1 without halt -> DONE with timed_out = 1, pass = 0.
REQ-032 Halt and timeout in the same cycle: halt wins.
REQ-033 CHECK lasts exactly one cycle; at its end register_v0 -> result; pass = (register_v0 == expected); timed_out = 0; -> DONE.
REQ-034 DONE holds outputs; start -> RUN with cycles cleared, program retained; clear -> IDLE.
REQ-035 clear in any state -> IDLE next edge, length = 0, overflow = 0, done/pass/timed_out = 0; clear beats start and load_en.
REQ-036 running, done SHALL be decoded from state only.

Reset
REQ-037 reset low SHALL immediately force IDLE, length = 0, cycles = 0, result = 0, running/done/pass/timed_out/overflow = 0.
REQ-038 Memory contents are not reset; length = 0 makes every fetch return NOP_WORD.
REQ-039 reset mid-RUN SHALL abort the run with no done pulse.

Verification
REQ-040 Load 3 words; fetch BASE_ADDR+0/4/8/C, BASE_ADDR+2, BASE_ADDR-4 -> words 0,1,2, then NOP_WORD three times.
REQ-041 Run; register_v0 = 44, expected = 44, halt at cycle 10 -> done after CHECK, pass = 1, result = 44, cycles = 10.
REQ-042 Same run, expected = 45 -> done, pass = 0, timed_out = 0, result = 44.
REQ-043 TIMEOUT = 8, halt never fetched -> done at cycles = 7, timed_out = 1, pass = 0; halt fetched on that same cycle -> CHECK instead.
REQ-044 DEPTH+1 loads -> length = DEPTH, overflow = 1, last word absent; clear -> overflow = 0, every fetch returns NOP_WORD.
REQ-045 reset low mid-RUN -> running = 0 asynchronously, IDLE, no done; start after release with no reload -> every fetch returns NOP_WORD.
